// File: rtl/vram_pkg.sv
// Shared types and default sizes for the VRAM arbiter and its host write FIFO.
package vram_pkg;

    localparam int ADDR_W_DEF     = 14;
    localparam int DATA_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_HWR,
        OWN_HRD
    } owner_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Host write FIFO: synchronous push/pop with an exact level count.
// Callers only push when !full and only pop when !empty.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wr_entry_t                  push_entry,
    input  logic                       pop,
    output wr_entry_t                  head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    wr_entry_t          mem_q [DEPTH];
    wr_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out reads first, buffered host writes next, host reads last.
// Optional stall statistics counter enabled with `define VRAM_ARB_STATS_EN.
//
// owner    | meaning
// OWN_NONE | idle slot, RAM not written
// OWN_DISP | scan-out read, data back two cycles later
// OWN_HWR  | FIFO head written to RAM
// OWN_HRD  | pending host read issued (FIFO already empty)
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic                          disp_rvalid,
    output logic [DATA_W-1:0]             disp_rdata,
    input  logic                          host_wr_req,
    input  logic [ADDR_W-1:0]             host_wr_addr,
    input  logic [DATA_W-1:0]             host_wr_data,
    output logic                          host_wr_ready,
    input  logic                          host_rd_req,
    input  logic [ADDR_W-1:0]             host_rd_addr,
    output logic                          host_rd_busy,
    output logic                          host_rd_valid,
    output logic [DATA_W-1:0]             host_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic                          ram_wren,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [15:0]                   stall_cnt
);

    owner_e             owner;
    owner_e             own1_q, own2_q;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               ram_wren_q, ram_wren_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_busy_q, rd_busy_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               ovf_q, ovf_d;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty, rd_accept;
    wr_entry_t          push_entry, fifo_head;

    assign host_wr_ready   = !fifo_full;
    assign fifo_push       = host_wr_req && host_wr_ready;
    assign push_entry.addr = host_wr_addr;
    assign push_entry.data = host_wr_data;
    assign fifo_pop        = (owner == OWN_HWR);
    assign rd_accept       = host_rd_req && !rd_busy_q;

    vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .level      (fifo_level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // A pending read only wins once the FIFO is empty, so it always sees earlier writes.
    always_comb begin
        owner = OWN_NONE;
        if (disp_req)        owner = OWN_DISP;
        else if (!fifo_empty) owner = OWN_HWR;
        else if (rd_pend_q)  owner = OWN_HRD;
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wren_d  = 1'b0;
        unique case (owner)
            OWN_DISP: ram_addr_d = disp_addr;
            OWN_HWR: begin
                ram_addr_d  = fifo_head.addr;
                ram_wdata_d = fifo_head.data;
                ram_wren_d  = 1'b1;
            end
            OWN_HRD:  ram_addr_d = rd_addr_q;
            default:  ram_addr_d = ram_addr_q;
        endcase

        rd_pend_d = rd_pend_q;
        rd_busy_d = rd_busy_q;
        rd_addr_d = rd_addr_q;
        if (owner == OWN_HRD) rd_pend_d = 1'b0;
        // busy falls as the returned data is presented
        if (own1_q == OWN_HRD) rd_busy_d = 1'b0;
        if (rd_accept) begin
            rd_pend_d = 1'b1;
            rd_busy_d = 1'b1;
            rd_addr_d = host_rd_addr;
        end
        rd_data_d = (own2_q == OWN_HRD) ? ram_rdata : rd_data_q;

        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (host_wr_req && !host_wr_ready) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own1_q      <= OWN_NONE;
            own2_q      <= OWN_NONE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_busy_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            own1_q      <= owner;
            own2_q      <= own1_q;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            rd_pend_q   <= rd_pend_d;
            rd_busy_q   <= rd_busy_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_wren      = ram_wren_q;
    assign disp_rvalid   = (own2_q == OWN_DISP);
    assign disp_rdata    = disp_rvalid ? ram_rdata : '0;
    assign host_rd_valid = (own2_q == OWN_HRD);
    assign host_rd_data  = host_rd_valid ? ram_rdata : rd_data_q;
    assign host_rd_busy  = rd_busy_q;
    assign ovf           = ovf_q;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (ovf_clr)
            stall_d = '0;
        else if (disp_req && (!fifo_empty || rd_pend_q) && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
